apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_pkg.sv | 28 ++
 rtl/apb_reg_file.sv | 83 ++++++++
 rtl/apb_reg_slave.sv | 95 +++++++++
 tb/tb_apb_reg_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// Shared constants, FSM state type and address-error rule for the APB register slave.
package apb_reg_pkg;

  localparam logic [31:0] ADDR_GROUP   = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATE    = 32'h0000_0004;
  localparam logic [31:0] ADDR_SURNAME = 32'h0000_0008;
  localparam logic [31:0] ADDR_NAME    = 32'h0000_000C;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0010;
  localparam logic [31:0] ADDR_ID      = 32'h0000_0014;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0409;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Misaligned, out of range, or a write aimed at one of the read-only registers.
  function automatic logic addr_error(input logic [31:0] addr, input logic write);
    logic err;
    err = (addr[1:0] != 2'b00) || (addr > ADDR_ID);
    if (write && ((addr == ADDR_STATUS) || (addr == ADDR_ID))) begin
      err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/apb_reg_file.sv
// Register storage, address decode, read mux and saturating transfer counters.
module apb_reg_file
  import apb_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_write,
  input  logic        i_pready,
  input  logic        i_commit,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [31:0] r_group;
  logic [31:0] r_date;
  logic [31:0] r_surname;
  logic [31:0] r_name;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  logic        w_err;
  logic        w_wr_en;
  logic        w_rd_en;
  logic [31:0] w_rd_value;

  assign w_err   = addr_error(i_addr, i_write);
  assign w_wr_en = i_commit && i_write && !w_err;
  assign w_rd_en = i_commit && !i_write && !w_err;
  assign o_err   = w_err;

  always_comb begin
    w_rd_value = 32'h0;
    case (i_addr)
      ADDR_GROUP:   w_rd_value = r_group;
      ADDR_DATE:    w_rd_value = r_date;
      ADDR_SURNAME: w_rd_value = r_surname;
      ADDR_NAME:    w_rd_value = r_name;
      ADDR_STATUS:  w_rd_value = {r_rd_cnt, r_wr_cnt};
      ADDR_ID:      w_rd_value = ID_VALUE;
      default:      w_rd_value = 32'h0;
    endcase
  end

  // Bus is driven only while a clean read is completing; errors read as zero.
  assign o_rdata = (i_pready && !i_write && !w_err) ? w_rd_value : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_group   <= 32'h0;
      r_date    <= 32'h0;
      r_surname <= 32'h0;
      r_name    <= 32'h0;
    end else if (w_wr_en) begin
      case (i_addr)
        ADDR_GROUP:   r_group   <= i_wdata;
        ADDR_DATE:    r_date    <= i_wdata;
        ADDR_SURNAME: r_surname <= i_wdata;
        ADDR_NAME:    r_name    <= i_wdata;
        default:      ;
      endcase
    end
  end

  // STATUS reads see the count before this read's own increment lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_cnt <= 16'h0;
      r_rd_cnt <= 16'h0;
    end else begin
      if (w_wr_en && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if (w_rd_en && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with programmable wait states in front of a small register file.
// Handshake: a transfer completes on the rising edge where psel, penable and pready are all 1.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        o_dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_addr;
  logic        r_write;
  logic        w_start;
  logic        w_commit;
  logic        w_pready;
  logic        w_err;

  assign w_pready    = (r_state == ST_ACCESS) && (r_wait_cnt == 4'd0);
  assign pready      = w_pready;
  assign pslverr     = w_pready && w_err;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // psel with penable high here is the master's trailing hold; ignore it.
        if (psel && !penable) begin
          w_start      = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          w_next_state = ST_IDLE;
        end else if (w_pready && penable) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 32'h0;
      r_write    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_addr     <= paddr;
        r_write    <= pwrite;
        r_wait_cnt <= WAIT_INIT;
      end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  apb_reg_file #(
    .ID_VALUE (ID_VALUE)
  ) u_reg_file (
    .i_clk    (pclk),
    .i_rst_n  (presetn),
    .i_addr   (r_addr),
    .i_write  (r_write),
    .i_pready (w_pready),
    .i_commit (w_commit),
    .i_wdata  (pwdata),
    .o_rdata  (prdata),
    .o_err    (w_err)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: directed APB transfers, expected responses queued and checked by a monitor.
module tb_apb_reg_slave;
  import apb_reg_pkg::*;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  // main DUT bus (WAIT_CYCLES = 1)
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr, dbg_state;

  // latency bus shared by the WAIT_CYCLES=0 and =3 instances
  logic [31:0] l_paddr, l_pwdata, l0_prdata, l3_prdata;
  logic        l_psel, l_penable, l_pwrite;
  logic        l0_pready, l0_pslverr, l0_state, l3_pready, l3_pslverr, l3_state;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  apb_reg_slave dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .o_dbg_state(dbg_state)
  );

  apb_reg_slave #(.WAIT_CYCLES(0)) dut_w0 (
    .pclk(pclk), .presetn(presetn), .paddr(l_paddr), .psel(l_psel), .penable(l_penable),
    .pwrite(l_pwrite), .pwdata(l_pwdata), .prdata(l0_prdata), .pready(l0_pready),
    .pslverr(l0_pslverr), .o_dbg_state(l0_state)
  );

  apb_reg_slave #(.WAIT_CYCLES(3)) dut_w3 (
    .pclk(pclk), .presetn(presetn), .paddr(l_paddr), .psel(l_psel), .penable(l_penable),
    .pwrite(l_pwrite), .pwdata(l_pwdata), .prdata(l3_prdata), .pready(l3_pready),
    .pslverr(l3_pslverr), .o_dbg_state(l3_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge pclk) begin
    if (presetn && psel && penable && pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response: got pslverr=%b prdata=%h expected no response", pslverr, prdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("pslverr", 32'(pslverr), 32'(mon_e[32]));
        check("prdata", prdata, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks (enter/exit at #1 after a rising edge) ----------------
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic err, input logic [31:0] rexp);
    int n;
    exp_q.push_back({err, (w || err) ? 32'h0 : rexp});
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    if (!pready) begin
      checks++;
      failures++;
      $display("FAIL pready_timeout: got no pready after %0d cycles expected pready", n);
      void'(exp_q.pop_back());
    end
    @(posedge pclk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(a, 1'b1, d, 1'b0, 32'h0);
  endtask

  task automatic wr_err(input logic [31:0] a, input logic [31:0] d);
    xfer(a, 1'b1, d, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    xfer(a, 1'b0, 32'h0, 1'b0, exp);
  endtask

  task automatic rd_err(input logic [31:0] a);
    xfer(a, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // master keeps psel/penable high after completion; slave must not restart
  task automatic trail();
    repeat (3) begin
      @(posedge pclk); #1;
    end
    check("trail_state", 32'(dbg_state), 32'(ST_IDLE));
    idle();
  endtask

  task automatic abort_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    check("abort_in_wait_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic latency_test();
    int lat0, lat3;
    logic [31:0] d0, d3;
    lat0 = 0; lat3 = 0; d0 = 32'h0; d3 = 32'h0;
    l_psel = 1'b1; l_penable = 1'b0; l_paddr = ADDR_ID;
    @(posedge pclk); #1;
    l_penable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (l0_pready && lat0 == 0) begin lat0 = k; d0 = l0_prdata; end
      if (l3_pready && lat3 == 0) begin lat3 = k; d3 = l3_prdata; end
      if (lat0 != 0 && lat3 != 0) break;
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    l_psel = 1'b0; l_penable = 1'b0;
    @(posedge pclk); #1;
    check("w0_ready_cycle", 32'(lat0), 32'd1);
    check("w3_ready_cycle", 32'(lat3), 32'd4);
    check("w0_id", d0, 32'hA9B0_0409);
    check("w3_id", d3, 32'hA9B0_0409);
    check("w0_state_after", 32'(l0_state), 32'(ST_IDLE));
    check("w3_state_after", 32'(l3_state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    presetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    l_psel = 1'b0; l_penable = 1'b0; l_pwrite = 1'b0; l_paddr = 32'h0; l_pwdata = 32'h0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    presetn = 1'b1;
    @(posedge pclk); #1;

    // basic write / read back
    wr(ADDR_GROUP, 32'd1);
    wr(ADDR_DATE, 32'd18112025);
    wr(ADDR_SURNAME, 32'h5052_4949);
    wr(ADDR_NAME, 32'h4B4F_4E53);
    idle();
    rd(ADDR_GROUP, 32'd1);
    rd(ADDR_DATE, 32'd18112025);
    idle();
    // 4 writes, 2 reads so far; the second STATUS read sees the first one
    rd(ADDR_STATUS, 32'h0002_0004);
    rd(ADDR_STATUS, 32'h0003_0004);
    idle();
    rd(ADDR_SURNAME, 32'h5052_4949);
    rd(ADDR_NAME, 32'h4B4F_4E53);
    rd(ADDR_ID, 32'hA9B0_0409);
    trail();

    // error accesses: no update, no count, zero read data
    wr_err(ADDR_STATUS, 32'hFFFF_FFFF);
    idle();
    wr_err(32'h18, 32'h1234_5678);
    wr_err(32'h02, 32'h5555_AAAA);
    wr_err(ADDR_ID, 32'h0BAD_0BAD);
    idle();
    rd_err(32'h06);
    rd_err(32'h1C);
    idle();
    rd(ADDR_STATUS, 32'h0007_0004);
    rd(ADDR_GROUP, 32'd1);
    rd(ADDR_DATE, 32'd18112025);
    rd(ADDR_SURNAME, 32'h5052_4949);
    rd(ADDR_NAME, 32'h4B4F_4E53);
    idle();

    // aborted write during wait state
    abort_write(ADDR_GROUP, 32'hDEAD_BEEF);
    rd(ADDR_GROUP, 32'd1);
    rd(ADDR_STATUS, 32'h000D_0004);
    idle();

    // back-to-back write then read of the same register
    wr(ADDR_NAME, 32'h4A4F_484E);
    rd(ADDR_NAME, 32'h4A4F_484E);
    idle();

    // reset pulse while a write to DATE is ready to complete
    psel = 1'b1; penable = 1'b0; paddr = ADDR_DATE; pwrite = 1'b1; pwdata = 32'h1111_2222;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check("pre_reset_pready", 32'(pready), 32'd1);
    presetn = 1'b0;
    psel = 1'b0; penable = 1'b0;
    #1;
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_pslverr", 32'(pslverr), 32'd0);
    check("midrst_prdata", prdata, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    rd(ADDR_DATE, 32'h0);
    rd(ADDR_NAME, 32'h0);
    rd(ADDR_STATUS, 32'h0002_0000);
    idle();

    // wait-state latency on the 0- and 3-cycle instances
    latency_test();

    repeat (2) @(posedge pclk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
